// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use stall.
// Drives the ALU operands, the ALU op code, and the controls carried on to MEM.
module ex_operand_stage #(
  parameter int XLEN       = 32,
  parameter int REGW       = 5,
  parameter int MASK_SHAMT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_alu_src,
  input  logic [2:0]      id_alu_control,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            flush,
  input  logic [REGW-1:0] mem_rd,
  input  logic            mem_reg_write,
  input  logic [XLEN-1:0] mem_result,
  input  logic [REGW-1:0] wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] SrcA,
  output logic [XLEN-1:0] SrcB,
  output logic [2:0]      ALUControl,
  output logic            ex_valid,
  output logic [REGW-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [XLEN-1:0] ex_store_data,
  output logic            stall
);

  logic            valid_q, alu_src_q, reg_write_q, mem_read_q, mem_write_q;
  logic [REGW-1:0] rs1_q, rs2_q, rd_q;
  logic [XLEN-1:0] rs1_data_q, rs2_data_q, imm_q;
  logic [2:0]      alu_control_q;

  logic            valid_d, alu_src_d, reg_write_d, mem_read_d, mem_write_d;
  logic [REGW-1:0] rs1_d, rs2_d, rd_d;
  logic [XLEN-1:0] rs1_data_d, rs2_data_d, imm_d;
  logic [2:0]      alu_control_d;

  logic            hazard;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2, srcb_raw;
  logic            shift_op;

  assign hazard = valid_q & mem_read_q & (rd_q != '0) & id_valid &
                  ((id_rs1 == rd_q) | (id_rs2 == rd_q));
  assign stall  = hazard & ~flush;

  always_comb begin
    valid_d       = id_valid;
    rs1_d         = id_rs1;
    rs2_d         = id_rs2;
    rd_d          = id_rd;
    rs1_data_d    = id_rs1_data;
    rs2_data_d    = id_rs2_data;
    imm_d         = id_imm;
    alu_src_d     = id_alu_src;
    alu_control_d = id_valid ? id_alu_control : 3'b000;
    reg_write_d   = id_valid & id_reg_write;
    mem_read_d    = id_valid & id_mem_read;
    mem_write_d   = id_valid & id_mem_write;
    // Flush wins over the load-use hazard; both load a fully zeroed bubble.
    if (flush || hazard) begin
      valid_d       = 1'b0;
      rs1_d         = '0;
      rs2_d         = '0;
      rd_d          = '0;
      rs1_data_d    = '0;
      rs2_data_d    = '0;
      imm_d         = '0;
      alu_src_d     = 1'b0;
      alu_control_d = 3'b000;
      reg_write_d   = 1'b0;
      mem_read_d    = 1'b0;
      mem_write_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= 1'b0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      rs1_data_q    <= '0;
      rs2_data_q    <= '0;
      imm_q         <= '0;
      alu_src_q     <= 1'b0;
      alu_control_q <= 3'b000;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rd_q          <= rd_d;
      rs1_data_q    <= rs1_data_d;
      rs2_data_q    <= rs2_data_d;
      imm_q         <= imm_d;
      alu_src_q     <= alu_src_d;
      alu_control_q <= alu_control_d;
      reg_write_q   <= reg_write_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
    end
  end

  // MEM is the younger producer, so it takes priority over WB; x0 never forwards.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs1_q))
      fwd_rs1 = mem_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs1_q))
      fwd_rs1 = wb_result;
  end

  always_comb begin
    fwd_rs2 = rs2_data_q;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs2_q))
      fwd_rs2 = mem_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs2_q))
      fwd_rs2 = wb_result;
  end

  assign shift_op = (MASK_SHAMT != 0) &&
                    ((alu_control_q == 3'b001) || (alu_control_q == 3'b101));
  assign srcb_raw = alu_src_q ? imm_q : fwd_rs2;

  always_comb begin
    SrcB = srcb_raw;
    if (shift_op)
      SrcB = {{(XLEN-5){1'b0}}, srcb_raw[4:0]};
  end

  assign SrcA          = fwd_rs1;
  assign ex_store_data = fwd_rs2;
  assign ALUControl    = alu_control_q;
  assign ex_valid      = valid_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: vector table for single-cycle behaviour,
// hand sequences for load-use stall/bubble and asynchronous reset.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_alu_src;
  logic [2:0]  id_alu_control;
  logic        id_reg_write, id_mem_read, id_mem_write, flush;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_result;
  logic [31:0] SrcA, SrcB, ex_store_data;
  logic [2:0]  ALUControl;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, stall;
  logic [4:0]  ex_rd;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_alu_control(id_alu_control),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .flush(flush),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data), .stall(stall)
  );

  typedef struct {
    logic        idv;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic        asrc;
    logic [2:0]  ctl;
    logic        rw, mr, mw, fl;
    logic [4:0]  mrd;
    logic        mrw;
    logic [31:0] mres;
    logic [4:0]  wrd;
    logic        wrw;
    logic [31:0] wres;
    logic        e_stall, e_v;
    logic [31:0] e_a, e_b, e_sd;
    logic [2:0]  e_ctl;
    logic [4:0]  e_rd;
    logic        e_rw, e_mr, e_mw;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.idv; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
    id_rs1_data = v.d1; id_rs2_data = v.d2; id_imm = v.imm;
    id_alu_src = v.asrc; id_alu_control = v.ctl;
    id_reg_write = v.rw; id_mem_read = v.mr; id_mem_write = v.mw; flush = v.fl;
    mem_rd = v.mrd; mem_reg_write = v.mrw; mem_result = v.mres;
    wb_rd = v.wrd; wb_reg_write = v.wrw; wb_result = v.wres;
  endtask

  task automatic id_inst(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic rw, input logic mr);
    id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = '0; id_imm = 32'h4; id_alu_src = mr;
    id_alu_control = 3'b000; id_reg_write = rw; id_mem_read = mr; id_mem_write = 1'b0;
    flush = 1'b0;
  endtask

  task automatic no_fwd();
    mem_rd = '0; mem_reg_write = 1'b0; mem_result = '0;
    wb_rd = '0; wb_reg_write = 1'b0; wb_result = '0;
  endtask

  initial begin
    // idv rs1 rs2 rd | d1 d2 imm | asrc ctl | rw mr mw fl | mrd mrw mres | wrd wrw wres | stall | v a b sd ctl rd rw mr mw
    vecs[0]  = '{1,1,2,3, 5,7,0, 0,0, 1,0,0,0, 0,0,0, 0,0,0, 0, 1,5,7,7,0,3,1,0,0};
    vecs[1]  = '{1,3,0,5, 'h99,0,0, 0,0, 1,0,0,0, 3,1,'h10, 3,1,'h20, 0, 1,'h10,0,0,0,5,1,0,0};
    vecs[2]  = '{1,3,0,5, 'h99,0,0, 0,0, 1,0,0,0, 3,0,'h10, 3,1,'h20, 0, 1,'h20,0,0,0,5,1,0,0};
    vecs[3]  = '{1,1,0,6, 1,0,0, 0,0, 1,0,0,0, 0,1,'hFFFF, 0,1,'h1234, 0, 1,1,0,0,0,6,1,0,0};
    vecs[4]  = '{1,6,7,9, 'h11,'h22,0, 0,2, 1,0,0,0, 6,1,'h600, 7,1,'h700, 0, 1,'h600,'h700,'h700,2,9,1,0,0};
    vecs[5]  = '{1,6,7,9, 'h11,'h22,'h44, 1,0, 1,0,0,0, 6,1,'h600, 7,1,'h700, 0, 1,'h600,'h44,'h700,0,9,1,0,0};
    vecs[6]  = '{1,1,2,10, 'h55,'h66,'h23, 1,1, 1,0,0,0, 0,0,0, 0,0,0, 0, 1,'h55,3,'h66,1,10,1,0,0};
    vecs[7]  = '{1,1,2,10, 'h55,'hFFFFFFE5,0, 0,5, 1,0,0,0, 0,0,0, 0,0,0, 0, 1,'h55,5,'hFFFFFFE5,5,10,1,0,0};
    vecs[8]  = '{1,1,2,10, 'h55,'h66,'h23, 1,3, 1,0,0,0, 0,0,0, 0,0,0, 0, 1,'h55,'h23,'h66,3,10,1,0,0};
    vecs[9]  = '{1,1,2,0, 'h100,'hBEEF,8, 1,0, 0,0,1,0, 0,0,0, 0,0,0, 0, 1,'h100,8,'hBEEF,0,0,0,0,1};
    vecs[10] = '{0,0,0,0, 0,0,0, 0,7, 1,1,1,0, 0,0,0, 0,0,0, 0, 0,0,0,0,0,0,0,0,0};
    vecs[11] = '{1,1,2,3, 5,7,0, 0,0, 1,0,0,1, 0,0,0, 0,0,0, 0, 0,0,0,0,0,0,0,0,0};
    vecs[12] = '{1,1,0,4, 'h200,0,4, 1,0, 1,1,0,0, 0,0,0, 0,0,0, 0, 1,'h200,4,0,0,4,1,1,0};
    vecs[13] = '{1,4,0,8, 0,0,0, 0,0, 1,0,0,1, 0,0,0, 0,0,0, 0, 0,0,0,0,0,0,0,0,0};
    vecs[14] = '{1,1,0,4, 'h200,0,4, 1,0, 1,1,0,0, 0,0,0, 0,0,0, 0, 1,'h200,4,0,0,4,1,1,0};

    rst = 1'b1;
    drive(vecs[10]);
    no_fwd();
    repeat (2) @(posedge clk);
    #1;
    chk("reset ex_valid", 32'(ex_valid), 0);
    chk("reset SrcA", SrcA, 0);
    chk("reset SrcB", SrcB, 0);
    chk("reset ALUControl", 32'(ALUControl), 0);
    chk("reset store_data", ex_store_data, 0);
    chk("reset stall", 32'(stall), 0);
    chk("reset ctrls", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d stall", i), 32'(stall), 32'(vecs[i].e_stall));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d ex_valid", i), 32'(ex_valid), 32'(vecs[i].e_v));
      chk($sformatf("v%0d SrcA", i), SrcA, vecs[i].e_a);
      chk($sformatf("v%0d SrcB", i), SrcB, vecs[i].e_b);
      chk($sformatf("v%0d store_data", i), ex_store_data, vecs[i].e_sd);
      chk($sformatf("v%0d ALUControl", i), 32'(ALUControl), 32'(vecs[i].e_ctl));
      chk($sformatf("v%0d ex_rd", i), 32'(ex_rd), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d ctrls", i), {29'd0, ex_reg_write, ex_mem_read, ex_mem_write},
          {29'd0, vecs[i].e_rw, vecs[i].e_mr, vecs[i].e_mw});
    end

    // Load-use: EX holds lw rd=4; dependent add waits one bubble, then takes WB value.
    id_inst(4, 0, 8, 32'h0, 1'b1, 1'b0);
    no_fwd();
    #1;
    chk("lu stall", 32'(stall), 1);
    @(posedge clk);
    #1;
    chk("lu bubble valid", 32'(ex_valid), 0);
    chk("lu bubble reg_write", 32'(ex_reg_write), 0);
    chk("lu bubble mem_read", 32'(ex_mem_read), 0);
    chk("lu stall one cycle", 32'(stall), 0);
    wb_rd = 5'd4; wb_reg_write = 1'b1; wb_result = 32'hABCD;
    @(posedge clk);
    #1;
    chk("lu captured valid", 32'(ex_valid), 1);
    chk("lu captured rd", 32'(ex_rd), 8);
    chk("lu wb forward SrcA", SrcA, 32'hABCD);

    // Asynchronous reset mid-stream with a live hazard.
    no_fwd();
    id_inst(1, 0, 4, 32'h300, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("pre-rst SrcA", SrcA, 32'h300);
    id_inst(4, 0, 8, 32'h0, 1'b1, 1'b0);
    #1;
    chk("pre-rst stall", 32'(stall), 1);
    rst = 1'b1;
    #1;
    chk("async rst ex_valid", 32'(ex_valid), 0);
    chk("async rst SrcA", SrcA, 0);
    chk("async rst SrcB", SrcB, 0);
    chk("async rst ALUControl", 32'(ALUControl), 0);
    chk("async rst stall", 32'(stall), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post-rst capture valid", 32'(ex_valid), 1);
    chk("post-rst capture rd", 32'(ex_rd), 8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-forwarding network.
- Sits directly upstream of the ALU and drives its SrcA, SrcB and ALUControl inputs.
- Resolves RAW hazards by forwarding from MEM and WB, and detects load-use hazards, raising a stall and inserting a bubble.
- Also carries destination and control bits forward to MEM.

Parameters:
- XLEN, 32, datapath width.
- REGW, 5, register index width.
- MASK_SHAMT, 1, when 1 SrcB is masked to its low 5 bits for shift ops.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs1, id_rs2  in  REGW  source register indices.
- id_rd  in  REGW  destination index.
- id_rs1_data, id_rs2_data  in  XLEN  register file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_alu_src  in  1  1 selects id_imm for SrcB.
- id_alu_control  in  3  ALU operation code.
- id_reg_write, id_mem_read, id_mem_write  in  1  decode controls.
- flush  in  1  kill the instruction entering EX (taken branch/jump).
- mem_rd  in  REGW  MEM-stage destination; mem_reg_write  in  1; mem_result  in  XLEN  MEM-stage ALU result.
- wb_rd  in  REGW  WB-stage destination; wb_reg_write  in  1; wb_result  in  XLEN  WB write-back value.
- SrcA, SrcB  out  XLEN  ALU operands.
- ALUControl  out  3  ALU operation code.
- ex_valid  out  1  EX slot holds a real instruction.
- ex_rd  out  REGW  destination index.
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  controls passed to MEM.
- ex_store_data  out  XLEN  forwarded rs2 value for stores.
- stall  out  1  hold PC and IF/ID this cycle.

Behaviour:
- Registered fields: valid, rs1, rs2, rd, rs1_data, rs2_data, imm, alu_src, alu_control, reg_write, mem_read, mem_write.
- On rst: all registered fields clear to 0 asynchronously.
  - Outputs then read: ex_valid=0, ALUControl=000, SrcA=0, SrcB=0, ex_store_data=0, stall=0, all ex_* controls 0.
- Load-use detection is combinational:
  - hazard = ex_valid & ex_mem_read & (ex_rd!=0) & ((id_rs1==ex_rd) | (id_rs2==ex_rd)) & id_valid.
  - stall = hazard & ~flush.
- Register update each rising edge:
  - flush=1: load bubble (valid, reg_write, mem_read, mem_write, alu_control all 0; data fields don't-care, drive 0).
  - Else hazard=1: load bubble. Upstream holds, so the same instruction is re-presented next cycle.
  - Else: capture all id_* inputs. id_valid=0 captures as a bubble with controls gated to 0.
- Flush overrides hazard.
  - Bubbles never assert ex_reg_write, ex_mem_read or ex_mem_write.
- Forwarding is combinational from registered rs1/rs2, per operand:
  - Value = mem_result if mem_reg_write & mem_rd!=0 & mem_rd==rs.
  - Else wb_result if wb_reg_write & wb_rd!=0 & wb_rd==rs.
  - Else registered data.
  - MEM has priority over WB; x0 is never forwarded.
- Operand outputs:
  - SrcA = forwarded rs1.
  - ex_store_data = forwarded rs2.
  - SrcB = alu_src ? imm : forwarded rs2.
  - If MASK_SHAMT=1 and alu_control is 001 or 101, SrcB[XLEN-1:5] is forced to 0.
- ALUControl = registered alu_control; a bubble presents 000 (add 0+0).
- Latency:
  - One cycle from id_* inputs to EX outputs.
  - Forwarding adds no cycles.
  - Load-use costs exactly one bubble; after it, the load sits in WB and is forwarded from wb_result.
- Reset mid-operation: the in-flight instruction is discarded and stall drops immediately.

Test Plan:
- Back-to-back capture: add rs1=1, rs2=2 with data 5 and 7, alu_src=0 -> next cycle SrcA=5, SrcB=7, ALUControl=000, ex_valid=1.
- MEM forwarding: EX rs1=3, mem_rd=3, mem_reg_write=1, mem_result=0x10, wb_rd=3, wb_result=0x20 -> SrcA=0x10 (MEM wins). Set mem_reg_write=0 -> SrcA=0x20.
- x0 guard: EX rs2=0, mem_rd=0, mem_reg_write=1, mem_result=0xFFFF, rs2_data=0 -> SrcB=0, ex_store_data=0.
- Load-use: EX holds lw to rd=4, ID presents rs1=4 -> stall=1 for exactly one cycle, next EX is a bubble (ex_valid=0, ex_reg_write=0). Following cycle the instruction is captured; wb_rd=4, wb_result=0xABCD -> SrcA=0xABCD.
- Flush over stall: load-use condition with flush=1 -> stall=0, bubble loaded.
- Shift mask and reset: ALUControl=001 with imm=0x23 -> SrcB=3. Assert rst mid-stream -> ex_valid=0, SrcA=SrcB=0, ALUControl=000 without waiting for a clock edge.
